vfp_class_pipe: RTL and testbench

// - Pipelined, multi-lane vector FP classifier for vfclass.v. Each beat carries LANES x 64 bits
//   of packed elements at SEW 16/32/64. Each active element is replaced by its 10-bit RISC-V

---
 rtl/vfp_class_pipe.sv | 179 +++++++++++++++++
 tb/tb_vfp_class_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vfp_class_pipe.sv
// Elastic multi-lane vector FP classifier (vfclass.v), SEW 16/32/64, with vl/v0 handling.
// Optional macro VFCLASS_FP16_EN enables SEW=16 decode; otherwise SEW=16 is reported illegal.
module vfp_class_pipe #(
    parameter int LANES  = 2,
    parameter int STAGES = 2,
    parameter int VL_W   = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  first_i,
    input  logic                  last_i,
    input  logic [1:0]            sew_i,
    input  logic [VL_W-1:0]       vl_i,
    input  logic                  vm_i,
    input  logic [LANES*4-1:0]    mask_i,
    input  logic [LANES*64-1:0]   operand_i,
    input  logic [LANES*64-1:0]   vd_old_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*64-1:0]   result_o,
    output logic                  last_o,
    output logic                  illegal_o
);
    localparam int W = LANES * 64;

    // Handshake: a beat moves on either side only in a cycle where valid && ready;
    // the output beat is held unchanged while out_valid_o && !out_ready_i.

    function automatic logic [9:0] fclass(input logic sgn, input logic exp_ones,
                                          input logic exp_zero, input logic mnt_zero,
                                          input logic mnt_msb);
        logic [9:0] c;
        c = '0;
        if (exp_ones) begin
            if (mnt_zero) c[sgn ? 0 : 7] = 1'b1;
            else          c[mnt_msb ? 9 : 8] = 1'b1;
        end else if (exp_zero) begin
            if (mnt_zero) c[sgn ? 3 : 4] = 1'b1;
            else          c[sgn ? 2 : 5] = 1'b1;
        end else begin
            c[sgn ? 1 : 6] = 1'b1;
        end
        return c;
    endfunction

    function automatic logic is_active(input int idx, input logic [VL_W-1:0] vl,
                                       input logic vm, input logic mb);
        return (idx < int'(vl)) && (vm || mb);
    endfunction

    logic [VL_W-1:0] bcnt_q, bcnt_d, eff_cnt;
    logic [W-1:0]    res0;
    logic            ill0;
    logic            accept;
    logic [63:0]     e64;
    logic [31:0]     e32;

    logic [STAGES-1:0] vld_q, vld_d, last_q, last_d, ill_q, ill_d;
    logic [W-1:0]      res_q [STAGES];
    logic [W-1:0]      res_d [STAGES];
    logic [STAGES-1:0] cap;

`ifdef VFCLASS_FP16_EN
    logic [15:0] e16;
`else
    logic unused_mask;
    assign unused_mask = ^mask_i[LANES*4-1:LANES*2];
`endif

    assign in_ready_o = !vld_q[STAGES-1] || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign eff_cnt    = first_i ? '0 : bcnt_q;

    // Stage 0: classify each active element in place at the current SEW.
    always_comb begin
        res0 = vd_old_i;
        ill0 = 1'b0;
        e64  = '0;
        e32  = '0;
`ifdef VFCLASS_FP16_EN
        e16  = '0;
`endif
        case (sew_i)
`ifdef VFCLASS_FP16_EN
            2'b00: begin
                for (int j = 0; j < LANES * 4; j++) begin
                    e16 = operand_i[16*j +: 16];
                    if (is_active(int'(eff_cnt) * (LANES * 4) + j, vl_i, vm_i, mask_i[j]))
                        res0[16*j +: 16] = {6'b0, fclass(e16[15], &e16[14:10], ~|e16[14:10],
                                                         ~|e16[9:0], e16[9])};
                end
            end
`endif
            2'b01: begin
                for (int j = 0; j < LANES * 2; j++) begin
                    e32 = operand_i[32*j +: 32];
                    if (is_active(int'(eff_cnt) * (LANES * 2) + j, vl_i, vm_i, mask_i[j]))
                        res0[32*j +: 32] = {22'b0, fclass(e32[31], &e32[30:23], ~|e32[30:23],
                                                          ~|e32[22:0], e32[22])};
                end
            end
            2'b10: begin
                for (int j = 0; j < LANES; j++) begin
                    e64 = operand_i[64*j +: 64];
                    if (is_active(int'(eff_cnt) * LANES + j, vl_i, vm_i, mask_i[j]))
                        res0[64*j +: 64] = {54'b0, fclass(e64[63], &e64[62:52], ~|e64[62:52],
                                                          ~|e64[51:0], e64[51])};
                end
            end
            default: ill0 = 1'b1;
        endcase
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (accept) bcnt_d = last_i ? '0 : eff_cnt + VL_W'(1);
    end

    // cap[k]: stage k can take a new beat this cycle (empty, or a hole/ready exists downstream).
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            cap[k] = out_ready_i;
            for (int m = k; m < STAGES; m++)
                if (!vld_q[m]) cap[k] = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            vld_d[k]  = vld_q[k];
            last_d[k] = last_q[k];
            ill_d[k]  = ill_q[k];
            res_d[k]  = res_q[k];
            if (k == 0) begin
                if (accept) begin
                    vld_d[k]  = 1'b1;
                    last_d[k] = last_i;
                    ill_d[k]  = ill0;
                    res_d[k]  = res0;
                end else if ((STAGES == 1) ? out_ready_i : cap[(k + 1) % STAGES]) begin
                    vld_d[k] = 1'b0;
                end
            end else begin
                if (vld_q[k-1] && cap[k]) begin
                    vld_d[k]  = 1'b1;
                    last_d[k] = last_q[k-1];
                    ill_d[k]  = ill_q[k-1];
                    res_d[k]  = res_q[k-1];
                end else if ((k == STAGES - 1) ? out_ready_i : cap[(k + 1) % STAGES]) begin
                    vld_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bcnt_q <= '0;
            vld_q  <= '0;
            last_q <= '0;
            ill_q  <= '0;
            for (int k = 0; k < STAGES; k++) res_q[k] <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            vld_q  <= vld_d;
            last_q <= last_d;
            ill_q  <= ill_d;
            for (int k = 0; k < STAGES; k++) res_q[k] <= res_d[k];
        end
    end

    assign out_valid_o = vld_q[STAGES-1];
    assign result_o    = res_q[STAGES-1];
    assign last_o      = last_q[STAGES-1];
    assign illegal_o   = ill_q[STAGES-1];

endmodule

// File: tb/tb_vfp_class_pipe.sv
// Directed bench for vfp_class_pipe: fixed vectors, scoreboard queue, stall and async-reset cases.
module tb_vfp_class_pipe;
    logic         clk, rst;
    logic         in_valid_i, in_ready_o, first_i, last_i, vm_i;
    logic [1:0]   sew_i;
    logic [10:0]  vl_i;
    logic [7:0]   mask_i;
    logic [127:0] operand_i, vd_old_i, result_o;
    logic         out_valid_o, out_ready_i, last_o, illegal_o;

    int tests = 0;
    int fails = 0;
    logic [129:0] exp_q[$];

    vfp_class_pipe #(.LANES(2), .STAGES(2), .VL_W(11)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .first_i(first_i), .last_i(last_i), .sew_i(sew_i), .vl_i(vl_i), .vm_i(vm_i),
        .mask_i(mask_i), .operand_i(operand_i), .vd_old_i(vd_old_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
        .last_o(last_o), .illegal_o(illegal_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [129:0] mk(input logic ill, input logic lst, input logic [127:0] r);
        return {ill, lst, r};
    endfunction

    // driver
    task automatic send(input logic f, input logic l, input logic [1:0] s, input logic [10:0] vl,
                        input logic vm, input logic [7:0] m, input logic [127:0] op,
                        input logic [127:0] vd, input logic [129:0] e);
        int n;
        @(negedge clk);
        in_valid_i = 1'b1; first_i = f; last_i = l; sew_i = s; vl_i = vl; vm_i = vm;
        mask_i = m; operand_i = op; vd_old_i = vd;
        n = 0;
        while (!in_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 130'(n), 130'(0));
        @(posedge clk);
        exp_q.push_back(e);
        #1 in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 130'(exp_q.size()), 130'(0));
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", mk(illegal_o, last_o, result_o), 130'(0) - 130'(1));
            end else begin
                chk("out_beat", mk(illegal_o, last_o, result_o), exp_q.pop_front());
            end
        end
    end

    logic [63:0] tbl_op [4];
    logic [63:0] tbl_cl [4];
    logic [127:0] vd16, r16;

    initial begin
        tbl_op[0] = 64'h7FF0000000000000; tbl_cl[0] = 64'h080;
        tbl_op[1] = 64'h0000000000000001; tbl_cl[1] = 64'h020;
        tbl_op[2] = 64'hBFF0000000000000; tbl_cl[2] = 64'h002;
        tbl_op[3] = 64'h0000000000000000; tbl_cl[3] = 64'h010;
        in_valid_i = 0; first_i = 0; last_i = 0; sew_i = 0; vl_i = 0; vm_i = 1;
        mask_i = 0; operand_i = 0; vd_old_i = 0; out_ready_i = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 130'(out_valid_o), 130'(0));
        chk("rst_result", 130'(result_o), 130'(0));
        chk("rst_last", 130'(last_o), 130'(0));
        chk("rst_illegal", 130'(illegal_o), 130'(0));
        chk("rst_in_ready", 130'(in_ready_o), 130'(1));

        // SEW64 qNaN / -inf, with latency check
        send(1, 1, 2'b10, 11'd2, 1, 8'h0, {64'hFFF0000000000000, 64'h7FF8000000000000}, '0,
             mk(0, 1, {64'h001, 64'h200}));
        @(negedge clk);
        chk("lat_cycle1", 130'(out_valid_o), 130'(0));
        @(negedge clk);
        chk("lat_cycle2", 130'(out_valid_o), 130'(1));

        send(1, 1, 2'b10, 11'd2, 1, 8'h0, {64'h8000000000000000, 64'h7FF0000000000001}, '0,
             mk(0, 1, {64'h008, 64'h100}));
        send(1, 1, 2'b01, 11'd4, 1, 8'h0,
             {32'h7F800000, 32'h00000000, 32'h3F800000, 32'h80000001}, '0,
             mk(0, 1, {32'h080, 32'h010, 32'h040, 32'h004}));
        // SEW32 vl=5 across two beats
        send(1, 0, 2'b01, 11'd5, 1, 8'h0,
             {32'h7FC00000, 32'h00000001, 32'hFF800000, 32'hBF800000}, {4{32'hAAAAAAAA}},
             mk(0, 0, {32'h200, 32'h020, 32'h001, 32'h002}));
        send(0, 1, 2'b01, 11'd5, 1, 8'h0,
             {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFFC00001}, {4{32'hAAAAAAAA}},
             mk(0, 1, {32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h200}));
        // v0 masking
        send(1, 1, 2'b01, 11'd4, 0, 8'b0101, '0, {4{32'h55555555}},
             mk(0, 1, {32'h55555555, 32'h010, 32'h55555555, 32'h010}));
        // vl=0 and reserved SEW
        send(1, 1, 2'b10, 11'd0, 1, 8'h0, {64'h7FF0000000000000, 64'h0}, {2{64'h3333333333333333}},
             mk(0, 1, {2{64'h3333333333333333}}));
        send(1, 1, 2'b11, 11'd2, 1, 8'h0, {64'h7FF0000000000000, 64'h0}, {2{64'h4444444444444444}},
             mk(1, 1, {2{64'h4444444444444444}}));
        // SEW16 +inf
        vd16 = {8{16'hCCCC}};
`ifdef VFCLASS_FP16_EN
        r16 = {vd16[127:16], 16'h0080};
        send(1, 1, 2'b00, 11'd1, 1, 8'h0, {112'h0, 16'h7C00}, vd16, mk(0, 1, r16));
`else
        r16 = vd16;
        send(1, 1, 2'b00, 11'd1, 1, 8'h0, {112'h0, 16'h7C00}, vd16, mk(1, 1, r16));
`endif
        drain();

        // 6-beat stream, vl=11, with a 3-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(i == 0, i == 5, 2'b10, 11'd11, 1, 8'h0,
                         {tbl_op[(i + 1) % 4], tbl_op[i % 4]},
                         {64'h1111111111111111, 64'h2222222222222222},
                         mk(0, i == 5, {(i == 5) ? 64'h1111111111111111 : tbl_cl[(i + 1) % 4],
                                        tbl_cl[i % 4]}));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #2 out_ready_i = 1'b0;
                @(negedge clk);
                chk("stall_in_ready", 130'(in_ready_o), 130'(0));
                repeat (3) @(posedge clk);
                #2 out_ready_i = 1'b1;
            end
        join
        drain();

        // async reset with beats in flight, then a continuation beat must see bcnt=0
        send(1, 0, 2'b10, 11'd4, 1, 8'h0, '0, '0, '0);
        send(0, 0, 2'b10, 11'd4, 1, 8'h0, '0, '0, '0);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 130'(out_valid_o), 130'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(0, 1, 2'b10, 11'd2, 1, 8'h0, {64'hFFF0000000000000, 64'h7FF8000000000000}, '0,
             mk(0, 1, {64'h001, 64'h200}));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
